regfile_wb_arbiter: RTL and testbench



---
 rtl/yari_pkg.sv | 16 +
 rtl/wb_rr_arbiter.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yari_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package yari_pkg;

    localparam int unsigned WBR_W            = 6;
    localparam int unsigned WBR_VALID_BIT    = 5;
    localparam int unsigned NREGS            = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    typedef logic [WBR_W-1:0] wbr_t;

    // A writeback reg performs a real write only when flagged and not targeting r0.
    function automatic logic wbr_writes(input wbr_t w);
        return w[WBR_VALID_BIT] & (|w[4:0]);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin one-hot picker: searches req starting at ptr, grants at most one when enabled.
module wb_rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ME stage first, then round-robin long-latency requesters,
// with pending-write scoreboard and starvation bubble. WBARB_PERF_EN adds perf counters.
module regfile_wb_arbiter
    import yari_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                m_valid,
    input  logic [5:0]          m_wbr,
    input  logic [31:0]         m_res,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [6*NREQ-1:0]   req_wbr,
    input  logic [32*NREQ-1:0]  req_res,
    output logic [NREQ-1:0]     req_ready,
    input  logic                iss_valid,
    input  logic [5:0]          iss_wbr,
    input  logic [5:0]          d_rs,
    input  logic [5:0]          d_rt,
    output logic                busy_rs,
    output logic                busy_rt,
    output logic                wb_valid,
    output logic [5:0]          wb_wbr,
    output logic [31:0]         wb_res,
    output logic                bubble_req
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0]         perf_wb_conflict,
    output logic [31:0]         perf_bubble
`endif
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NREGS-1:0] sb_q, sb_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             bubble_q, bubble_d;
    logic             wb_valid_q, wb_valid_d;
    wbr_t             wb_wbr_q, wb_wbr_d;
    logic [31:0]      wb_res_q, wb_res_d;

    logic             me_write;
    logic             any_grant;
    wbr_t             win_wbr;
    logic [31:0]      win_res;

    assign me_write  = m_valid & m_wbr[WBR_VALID_BIT];
    assign any_grant = |req_ready;

    wb_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (~me_write),
        .grant  (req_ready)
    );

    // Winner select and pointer advance; grant is one-hot so OR-reduction is a mux.
    always_comb begin
        win_wbr = '0;
        win_res = '0;
        ptr_d   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_wbr = win_wbr | req_wbr[WBR_W*i +: WBR_W];
                win_res = win_res | req_res[32*i +: 32];
                ptr_d   = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Clear first, then set, so a same-cycle issue to the same reg keeps the bit.
    always_comb begin
        sb_d = sb_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sb_d[req_wbr[WBR_W*i +: 5]] = 1'b0;
            end
        end
        if (iss_valid && wbr_writes(iss_wbr)) begin
            sb_d[iss_wbr[4:0]] = 1'b1;
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_wbr_d   = wb_wbr_q;
        wb_res_d   = wb_res_q;
        if (me_write) begin
            wb_valid_d = 1'b1;
            wb_wbr_d   = m_wbr;
            wb_res_d   = m_res;
        end else if (any_grant) begin
            wb_valid_d = wbr_writes(win_wbr);
            wb_wbr_d   = win_wbr;
            wb_res_d   = win_res;
        end
    end

    // Saturating at LIMIT keeps the bubble to a single pulse per starvation episode.
    always_comb begin
        cnt_d    = cnt_q;
        bubble_d = 1'b0;
        if (any_grant || !(|req_valid)) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d    = cnt_q + 8'd1;
            bubble_d = (cnt_q == LIMIT - 8'd1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            bubble_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wbr_q   <= '0;
            wb_res_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            bubble_q   <= bubble_d;
            wb_valid_q <= wb_valid_d;
            wb_wbr_q   <= wb_wbr_d;
            wb_res_q   <= wb_res_d;
        end
    end

    assign busy_rs    = d_rs[WBR_VALID_BIT] & sb_q[d_rs[4:0]];
    assign busy_rt    = d_rt[WBR_VALID_BIT] & sb_q[d_rt[4:0]];
    assign wb_valid   = wb_valid_q;
    assign wb_wbr     = wb_wbr_q;
    assign wb_res     = wb_res_q;
    assign bubble_req = bubble_q;

`ifdef WBARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_bubble_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflict_q <= '0;
            perf_bubble_q   <= '0;
        end else begin
            if (me_write && (|req_valid)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            if (bubble_d) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_wb_conflict = perf_conflict_q;
    assign perf_bubble      = perf_bubble_q;
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=2, STARVE_LIMIT=8).
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m_valid;
    logic [5:0]  m_wbr;
    logic [31:0] m_res;
    logic [1:0]  req_valid;
    logic [11:0] req_wbr;
    logic [63:0] req_res;
    logic [1:0]  req_ready;
    logic        iss_valid;
    logic [5:0]  iss_wbr;
    logic [5:0]  d_rs;
    logic [5:0]  d_rt;
    logic        busy_rs;
    logic        busy_rt;
    logic        wb_valid;
    logic [5:0]  wb_wbr;
    logic [31:0] wb_res;
    logic        bubble_req;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(
        .NREQ         (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m_valid    (m_valid),
        .m_wbr      (m_wbr),
        .m_res      (m_res),
        .req_valid  (req_valid),
        .req_wbr    (req_wbr),
        .req_res    (req_res),
        .req_ready  (req_ready),
        .iss_valid  (iss_valid),
        .iss_wbr    (iss_wbr),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .busy_rs    (busy_rs),
        .busy_rt    (busy_rt),
        .wb_valid   (wb_valid),
        .wb_wbr     (wb_wbr),
        .wb_res     (wb_res),
        .bubble_req (bubble_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [1:0]  rr_ready [4];
    logic [5:0]  rr_wbr   [4];
    logic [31:0] rr_res   [4];
    int          n_bubble;
    int          bubble_at;

    initial begin
        rr_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_wbr   = '{6'h21, 6'h22, 6'h21, 6'h22};
        rr_res   = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hA0A0_0000, 32'hB1B1_1111};

        reset_n   = 1'b0;
        m_valid   = 1'b0;
        m_wbr     = '0;
        m_res     = '0;
        req_valid = '0;
        req_wbr   = '0;
        req_res   = '0;
        iss_valid = 1'b0;
        iss_wbr   = '0;
        d_rs      = 6'h25;
        d_rt      = 6'h27;
        #12;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_wbr", 64'(wb_wbr), 64'd0);
        check("rst_wb_res", 64'(wb_res), 64'd0);
        check("rst_bubble", 64'(bubble_req), 64'd0);
        check("rst_busy", 64'({busy_rs, busy_rt}), 64'd0);
        reset_n = 1'b1;
        tick();

        // ME priority over a pending requester
        m_valid   = 1'b1;
        m_wbr     = 6'h22;
        m_res     = 32'hDEAD_BEEF;
        req_valid = 2'b01;
        req_wbr   = {6'h00, 6'h21};
        #1;
        check("me_ready", 64'(req_ready), 64'd0);
        tick();
        m_valid   = 1'b0;
        req_valid = 2'b00;
        check("me_wb_valid", 64'(wb_valid), 64'd1);
        check("me_wb_wbr", 64'(wb_wbr), 64'h22);
        check("me_wb_res", 64'(wb_res), 64'hDEAD_BEEF);
        tick();
        check("idle_wb_valid", 64'(wb_valid), 64'd0);
        check("idle_wb_hold", 64'(wb_res), 64'hDEAD_BEEF);

        // Round-robin alternation
        req_valid = 2'b11;
        req_wbr   = {6'h22, 6'h21};
        req_res   = {32'hB1B1_1111, 32'hA0A0_0000};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(rr_ready[k]));
            tick();
            check($sformatf("rr_wbr%0d", k), 64'(wb_wbr), 64'(rr_wbr[k]));
            check($sformatf("rr_res%0d", k), 64'(wb_res), 64'(rr_res[k]));
            check($sformatf("rr_valid%0d", k), 64'(wb_valid), 64'd1);
        end
        req_valid = 2'b00;

        // Scoreboard set, query, clear
        iss_valid = 1'b1;
        iss_wbr   = 6'h25;
        d_rs      = 6'h25;
        d_rt      = 6'h05;
        tick();
        iss_valid = 1'b0;
        check("sb_set_rs", 64'(busy_rs), 64'd1);
        check("sb_rt_invalid", 64'(busy_rt), 64'd0);
        d_rt = 6'h25;
        #1;
        check("sb_set_rt", 64'(busy_rt), 64'd1);
        req_valid = 2'b10;
        req_wbr   = {6'h25, 6'h00};
        req_res   = {32'h1234_5678, 32'h0};
        #1;
        check("sb_clr_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        check("sb_clr_rs", 64'(busy_rs), 64'd0);
        check("sb_clr_wbr", 64'(wb_wbr), 64'h25);

        // r0 is never marked busy
        iss_valid = 1'b1;
        iss_wbr   = 6'h20;
        d_rs      = 6'h20;
        tick();
        iss_valid = 1'b0;
        check("sb_r0", 64'(busy_rs), 64'd0);

        // Same-cycle clear and set of r7: set wins
        iss_valid = 1'b1;
        iss_wbr   = 6'h27;
        d_rs      = 6'h27;
        tick();
        check("col_pre", 64'(busy_rs), 64'd1);
        req_valid = 2'b01;
        req_wbr   = {6'h00, 6'h27};
        req_res   = {32'h0, 32'h7777_7777};
        #1;
        check("col_ready", 64'(req_ready), 64'b01);
        tick();
        iss_valid = 1'b0;
        check("col_set_wins", 64'(busy_rs), 64'd1);
        tick();
        req_valid = 2'b00;
        check("col_clear", 64'(busy_rs), 64'd0);

        // Non-writing requester is consumed without a regfile write
        req_valid = 2'b01;
        req_wbr   = {6'h00, 6'h0A};
        #1;
        check("nw_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        check("nw_wb_valid", 64'(wb_valid), 64'd0);
        tick();

        // Starvation under a continuous ME write stream
        m_valid   = 1'b1;
        m_wbr     = 6'h23;
        m_res     = 32'h5555_AAAA;
        req_valid = 2'b01;
        req_wbr   = {6'h00, 6'h2C};
        req_res   = {32'h0, 32'hC0C0_C0C0};
        n_bubble  = 0;
        bubble_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bubble_req) begin
                n_bubble++;
                if (bubble_at < 0) bubble_at = k;
            end
        end
        check("starve_pulses", 64'(n_bubble), 64'd1);
        check("starve_cycle", 64'(bubble_at), 64'd8);
        m_valid = 1'b0;
        #1;
        check("starve_grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        check("starve_wbr", 64'(wb_wbr), 64'h2C);
        check("starve_res", 64'(wb_res), 64'hC0C0_C0C0);
        check("starve_bubble_off", 64'(bubble_req), 64'd0);

        // Asynchronous reset mid-operation
        iss_valid = 1'b1;
        iss_wbr   = 6'h23;
        tick();
        iss_wbr   = 6'h29;
        m_valid   = 1'b1;
        m_wbr     = 6'h2F;
        tick();
        iss_valid = 1'b0;
        m_valid   = 1'b0;
        d_rs      = 6'h23;
        d_rt      = 6'h29;
        #1;
        check("ar_pre_busy", 64'({busy_rs, busy_rt}), 64'b11);
        check("ar_pre_wb", 64'(wb_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_busy", 64'({busy_rs, busy_rt}), 64'd0);
        check("ar_wb_valid", 64'(wb_valid), 64'd0);
        check("ar_wb_wbr", 64'(wb_wbr), 64'd0);
        #3;
        reset_n = 1'b1;
        tick();
        check("ar_post_busy", 64'({busy_rs, busy_rt}), 64'd0);
        check("ar_post_bubble", 64'(bubble_req), 64'd0);
        req_valid = 2'b11;
        #1;
        check("ar_ptr_zero", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
